dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter RAM_SPACE, default 4096, the data memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LOCK_MAX, default 16, the maximum number of consecutive grants port 1 may hold under lock.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports p0_req_valid (input, 1) and p0_req_ready (output, 1): port 0 (core LSU) request handshake.
REQ-006 SHALL have ports p0_addr (input, 32), p0_wdata (input, 32) and p0_wstrb (input, 4): port 0 byte address, write data and byte write enables; a wstrb value of 0 denotes a read.
REQ-007 SHALL have ports p0_rsp_valid (output, 1), p0_rdata (output, 32) and p0_rsp_err (output, 1): port 0 response.
REQ-008 SHALL have ports p1_req_valid, p1_req_ready, p1_addr, p1_wdata, p1_wstrb, p1_rsp_valid, p1_rdata and p1_rsp_err, with the same directions, widths and meanings as port 0; port 1 is the DMA/debug port.
REQ-009 SHALL have port p1_lock, input, 1 bit: port 1 requests back-to-back grants (burst).
REQ-010 SHALL have ports en_mem (output, 1), addr_mem (output, 32), w_data_mem (output, 32) and w_en_mem (output, 4): the memory-side command.
REQ-011 SHALL have port r_data_mem, input, 32 bits: memory read data, valid one cycle after en_mem.

Function
REQ-012 SHALL issue at most one access per cycle; a request is accepted in the cycle where req_valid and req_ready are both 1.
REQ-013 SHALL compute req_ready combinationally; it is asserted only to the single arbitration winner.
REQ-014 SHALL use round-robin arbitration with a 1-bit pointer favouring the port not granted last; a grant updates the pointer.
REQ-015 SHALL grant the sole requester immediately when only one port is valid, whatever the pointer.
REQ-016 SHALL grant port 1 every cycle it is valid while p1_lock=1 and the lock counter is below LOCK_MAX; the lock counter increments per locked grant.
REQ-017 SHALL force one round-robin decision when the lock counter reaches LOCK_MAX and port 0 is valid: port 0 wins and the lock counter clears. The counter also clears when p1_lock=0 or port 0 is granted.
REQ-018 SHALL, on an accepted in-range request, drive in the same cycle: en_mem=1, addr_mem=req addr, w_data_mem=wdata, w_en_mem=wstrb. When nothing is issued, en_mem=0 and w_en_mem=0.
REQ-019 SHALL treat an address as in range when addr[31:2] < RAM_SPACE; addr[1:0] pass through unchanged.
REQ-020 SHALL accept an out-of-range request without asserting en_mem, and respond with rsp_err=1 and rdata=0.
REQ-021 SHALL assert the issuing port's rsp_valid for exactly one cycle, in the cycle after acceptance. Responses cannot be back-pressured.
REQ-022 SHALL route r_data_mem to rdata for an in-range read, and drive rdata=0 for writes and for the non-responding port.
REQ-023 SHALL register the issuing port id, read/write flag and error flag for one cycle to steer the response; back-to-back accepts are fully pipelined (throughput 1/cycle).

Reset
REQ-024 SHALL, while rst=1, drive all outputs to 0 (req_ready, rsp_valid, rsp_err, rdata, en_mem, w_en_mem, addr_mem, w_data_mem), set the pointer to favour port 0, and clear the lock counter and response pipeline.
REQ-025 SHALL drop any response still in flight when rst asserts mid-operation; the first grant after reset release is possible on the first clock edge.

Verification
REQ-026 SHALL be verified as follows: p0 write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then p0 read 0x10 -> second response rdata=0xDEADBEEF, rsp_err=0, one cycle after acceptance.
REQ-027 SHALL be verified as follows: both ports valid every cycle, no lock, after reset -> grants alternate p0, p1, p0, p1, and en_mem=1 every cycle.
REQ-028 SHALL be verified as follows: p1_lock=1 with both ports valid for 40 cycles, LOCK_MAX=16 -> 16 p1 grants, then 1 p0 grant, repeating.
REQ-029 SHALL be verified as follows: p1 read addr 0x4000 with RAM_SPACE=4096 -> en_mem stays 0, next cycle p1_rsp_valid=1, p1_rsp_err=1, p1_rdata=0.
REQ-030 SHALL be verified as follows: p0 byte write wstrb=0x2 to 0x20 -> w_en_mem=0x2, addr_mem=0x20, and p0_rsp_valid=1 with rdata=0 the next cycle.
REQ-031 SHALL be verified as follows: rst asserted in the cycle after a p0 read is accepted -> no p0_rsp_valid is observed, and all outputs are 0 during reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin between core LSU (port 0) and DMA/debug
// (port 1), with a bounded burst lock for port 1 and a one-cycle response pipeline.
module dmem_arbiter #(
  parameter int RAM_SPACE = 4096,
  parameter int LOCK_MAX  = 16
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rdata,
  output logic        p0_rsp_err,

  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rdata,
  output logic        p1_rsp_err,
  input  logic        p1_lock,

  output logic        en_mem,
  output logic [31:0] addr_mem,
  output logic [31:0] w_data_mem,
  output logic [3:0]  w_en_mem,
  input  logic [31:0] r_data_mem
);

  localparam int          CNT_W     = $clog2(LOCK_MAX + 1);
  localparam logic [29:0] RAM_WORDS = 30'(RAM_SPACE);

  typedef enum logic {FAV_P0 = 1'b0, FAV_P1 = 1'b1} rr_state_t;

  rr_state_t        ptr_reg, ptr_next;
  logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic             rsp0_reg, rsp0_next;
  logic             rsp1_reg, rsp1_next;
  logic             rsp_rd_reg, rsp_rd_next;
  logic             rsp_err_reg, rsp_err_next;

  logic             grant0, grant1, lock_full, in_range, issue;
  logic [31:0]      sel_addr, sel_wdata;
  logic [3:0]       sel_wstrb;

  assign lock_full = (lock_cnt_reg >= CNT_W'(LOCK_MAX));

  // Lock wins until its budget is spent; then a contending port 0 is forced through.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (p1_req_valid && p1_lock && !lock_full) begin
      grant1 = 1'b1;
    end else if (p0_req_valid && p1_req_valid) begin
      if (lock_full || ptr_reg == FAV_P0) grant0 = 1'b1;
      else                                grant1 = 1'b1;
    end else begin
      grant0 = p0_req_valid;
      grant1 = p1_req_valid;
    end
  end

  always_comb begin
    sel_addr  = grant1 ? p1_addr  : p0_addr;
    sel_wdata = grant1 ? p1_wdata : p0_wdata;
    sel_wstrb = grant1 ? p1_wstrb : p0_wstrb;
    in_range  = (sel_addr[31:2] < RAM_WORDS);
    issue     = (grant0 | grant1) & in_range;
  end

  // Outputs are forced low while reset is held; internal next-state stays ungated.
  assign p0_req_ready = grant0 & ~rst;
  assign p1_req_ready = grant1 & ~rst;
  assign en_mem       = issue & ~rst;
  assign addr_mem     = en_mem ? sel_addr  : 32'd0;
  assign w_data_mem   = en_mem ? sel_wdata : 32'd0;
  assign w_en_mem     = en_mem ? sel_wstrb : 4'd0;

  assign p0_rsp_valid = rsp0_reg;
  assign p1_rsp_valid = rsp1_reg;
  assign p0_rsp_err   = rsp0_reg & rsp_err_reg;
  assign p1_rsp_err   = rsp1_reg & rsp_err_reg;
  assign p0_rdata     = (rsp0_reg && rsp_rd_reg && !rsp_err_reg) ? r_data_mem : 32'd0;
  assign p1_rdata     = (rsp1_reg && rsp_rd_reg && !rsp_err_reg) ? r_data_mem : 32'd0;

  always_comb begin
    ptr_next      = ptr_reg;
    lock_cnt_next = lock_cnt_reg;
    rsp0_next     = grant0;
    rsp1_next     = grant1;
    rsp_rd_next   = (sel_wstrb == 4'd0);
    rsp_err_next  = ~in_range;
    if (grant0)      ptr_next = FAV_P1;
    else if (grant1) ptr_next = FAV_P0;
    if (!p1_lock || grant0)
      lock_cnt_next = '0;
    else if (grant1 && !lock_full)
      lock_cnt_next = lock_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg      <= FAV_P0;
      lock_cnt_reg <= '0;
      rsp0_reg     <= 1'b0;
      rsp1_reg     <= 1'b0;
      rsp_rd_reg   <= 1'b0;
      rsp_err_reg  <= 1'b0;
    end else begin
      ptr_reg      <= ptr_next;
      lock_cnt_reg <= lock_cnt_next;
      rsp0_reg     <= rsp0_next;
      rsp1_reg     <= rsp1_next;
      rsp_rd_reg   <= rsp_rd_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

endmodule
